// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM state encoding, mem_size bit
// positions and the size/lane helpers used by the control logic.
package mem_responder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;
  localparam state_t ST_HOLD = 2'd3;

  // mem_size one-hot positions; all-zero means a full word
  localparam int SZ_BYTE_S = 3;
  localparam int SZ_BYTE_U = 2;
  localparam int SZ_HALF_S = 1;
  localparam int SZ_HALF_U = 0;

  typedef enum logic [1:0] {ACC_WORD, ACC_HALF, ACC_BYTE} acc_width_e;

  typedef struct packed {
    acc_width_e width;
    logic       sext;
  } acc_kind_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  size;
    logic [31:0] wdata;
    logic        is_read;
  } req_t;

  // Higher size bits win when an initiator sets more than one.
  function automatic acc_kind_t decode_size(input logic [3:0] size);
    acc_kind_t k;
    k = '{width: ACC_WORD, sext: 1'b0};
    if (size[SZ_BYTE_S])      k = '{width: ACC_BYTE, sext: 1'b1};
    else if (size[SZ_BYTE_U]) k = '{width: ACC_BYTE, sext: 1'b0};
    else if (size[SZ_HALF_S]) k = '{width: ACC_HALF, sext: 1'b1};
    else if (size[SZ_HALF_U]) k = '{width: ACC_HALF, sext: 1'b0};
    return k;
  endfunction

  function automatic logic [3:0] lane_mask(input acc_kind_t k, input logic [1:0] a);
    case (k.width)
      ACC_BYTE: return 4'b0001 << a;
      ACC_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

  // Replicating the store data lets the lane mask alone pick the target bytes.
  function automatic logic [31:0] store_data(input acc_kind_t k, input logic [31:0] d);
    case (k.width)
      ACC_BYTE: return {4{d[7:0]}};
      ACC_HALF: return {2{d[15:0]}};
      default:  return d;
    endcase
  endfunction

  function automatic logic [31:0] load_data(input acc_kind_t k, input logic [1:0] a,
                                            input logic [31:0] word);
    logic [31:0] sh;
    logic [15:0] h;
    sh = word >> {a, 3'b000};
    h  = a[1] ? word[31:16] : word[15:0];
    case (k.width)
      ACC_BYTE: return k.sext ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      ACC_HALF: return k.sext ? {{16{h[15]}}, h} : {16'h0, h};
      default:  return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Backing store: one synchronous read/write port with per-byte write enables.
module mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: storage has no reset; contents survive rst and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-stated memory responder: accepts a strobed request, waits WAIT_STATES
// cycles, performs the array access and pulses mem_data_ready once.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] bus,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_size,
  input  logic        mem_addr_ready,
  output logic        mem_data_ready,
  output logic [31:0] mem_bus_out,
  output logic        mem_bus_oe,
  output logic        mem_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d, req_in, req_cur;
  logic        data_ready_q, data_ready_d;
  logic        oe_q, oe_d;
  logic        err_q, err_d;
  logic        accept, fire, in_range, arr_en;
  acc_kind_t   kind_cur, kind_q;
  logic [3:0]  arr_we;
  logic [31:0] arr_wdata, arr_rdata;

  assign req_in = '{addr: addr, size: mem_size, wdata: bus, is_read: mem_read};
  assign accept = (state_q == ST_IDLE) && mem_addr_ready && (mem_read || mem_write);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        req_d   = req_in;
        cnt_d   = 4'(WAIT_STATES);
        state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: if (!mem_addr_ready) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_HOLD;
      ST_HOLD: if (!mem_addr_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The access fires on the edge entering RESP; with no wait states that is
  // the acceptance edge itself, so the live request is used straight from IDLE.
  always_comb begin
    req_cur      = (state_q == ST_IDLE) ? req_in : req_q;
    kind_cur     = decode_size(req_cur.size);
    in_range     = {2'b00, req_cur.addr[31:2]} < 32'(DEPTH_WORDS);
    fire         = (state_d == ST_RESP);
    arr_en       = fire && in_range && reset;
    arr_we       = req_cur.is_read ? 4'b0000 : lane_mask(kind_cur, req_cur.addr[1:0]);
    arr_wdata    = store_data(kind_cur, req_cur.wdata);
    data_ready_d = fire;
    err_d        = fire && !in_range;
    oe_d         = fire && req_cur.is_read;
  end

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .idx   (req_cur.addr[AW+1:2]),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      data_ready_q <= 1'b0;
      oe_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      data_ready_q <= data_ready_d;
      oe_q         <= oe_d;
      err_q        <= err_d;
    end
  end

  // The array's read register holds the word; only lane select and extension follow it.
  always_comb begin
    kind_q      = decode_size(req_q.size);
    mem_bus_out = '0;
    if (oe_q && !err_q) mem_bus_out = load_data(kind_q, req_q.addr[1:0], arr_rdata);
  end

  assign mem_data_ready = data_ready_q;
  assign mem_bus_oe     = oe_q;
  assign mem_err        = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with WAIT_STATES=1, one
// with WAIT_STATES=3, sharing the request bus but with separate strobes.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, bus;
  logic        mem_read, mem_write;
  logic [3:0]  mem_size;
  logic [1:0]  ar;
  wire  [1:0]  dr, oe, err;
  wire  [31:0] out0, out1;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .reset(reset), .addr(addr), .bus(bus), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_addr_ready(ar[0]),
    .mem_data_ready(dr[0]), .mem_bus_out(out0), .mem_bus_oe(oe[0]), .mem_err(err[0]));

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut_ws3 (
    .clk(clk), .reset(reset), .addr(addr), .bus(bus), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_addr_ready(ar[1]),
    .mem_data_ready(dr[1]), .mem_bus_out(out1), .mem_bus_oe(oe[1]), .mem_err(err[1]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    logic        rd;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  task automatic score(input int k, input logic [31:0] out, input logic oe_v, input logic err_v);
    exp_t e;
    if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
      check("unexpected_pulse", {31'b0, dr[k]}, 32'h0);
    end else begin
      e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
      check({e.tag, "_data"}, out, e.data);
      check({e.tag, "_err"}, {31'b0, err_v}, {31'b0, e.err});
      check({e.tag, "_oe"}, {31'b0, oe_v}, {31'b0, e.rd});
    end
  endtask

  always @(negedge clk) begin
    if (dr[0]) score(0, out0, oe[0], err[0]);
    if (dr[1]) score(1, out1, oe[1], err[1]);
  end

  // One full handshake: strobe, wait for the pulse, hold, release.
  task automatic req(input int k, input string tag, input logic rd, input logic wr,
                     input logic [3:0] sz, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_data, input logic exp_err, input int hold);
    int lat;
    bit seen;
    exp_t e;
    @(negedge clk);
    addr = a; bus = d; mem_read = rd; mem_write = wr; mem_size = sz; ar[k] = 1'b1;
    e = '{tag, rd ? exp_data : 32'h0, exp_err, rd};
    if (k == 0) sb0.push_back(e); else sb1.push_back(e);
    lat = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = dr[k];
    end
    check({tag, "_lat"}, seen ? 32'(lat) : 32'hFFFF, (k == 0) ? 32'd2 : 32'd4);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_dr"}, {31'b0, dr[k]}, 32'h0);
      check({tag, "_hold_oe"}, {31'b0, oe[k]}, 32'h0);
    end
    ar[k] = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  logic [31:0] model [4];

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [3:0] sz);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = model[a[3:2]];
    b = w[8*a[1:0] +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    if (sz[3])      return {{24{b[7]}}, b};
    else if (sz[2]) return {24'h0, b};
    else if (sz[1]) return {{16{h[15]}}, h};
    else if (sz[0]) return {16'h0, h};
    return w;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [3:0] sz, input logic [31:0] d);
    if (sz[3] || sz[2])      model[a[3:2]][8*a[1:0] +: 8] = d[7:0];
    else if (sz[1] || sz[0]) begin
      if (a[1]) model[a[3:2]][31:16] = d[15:0];
      else      model[a[3:2]][15:0]  = d[15:0];
    end else model[a[3:2]] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]  szs [5];
    logic [31:0] a, d;
    logic [3:0]  sz;
    logic        rd;
    szs = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    reset = 1'b0; addr = '0; bus = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_size = '0; ar = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_dr", {31'b0, dr[k]}, 32'h0);
      check("rst_oe", {31'b0, oe[k]}, 32'h0);
      check("rst_err", {31'b0, err[k]}, 32'h0);
    end
    check("rst_out0", out0, 32'h0);
    check("rst_out1", out1, 32'h0);
    reset = 1'b1;

    // Word write/read and sub-word extension
    req(0, "w_word", 0, 1, 4'b0000, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1);
    req(0, "r_word", 1, 0, 4'b0000, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1);
    req(0, "r_bs", 1, 0, 4'b1000, 32'h103, 32'h0, 32'hFFFFFFDE, 0, 1);
    req(0, "r_bu", 1, 0, 4'b0100, 32'h103, 32'h0, 32'h000000DE, 0, 1);
    req(0, "r_hs", 1, 0, 4'b0010, 32'h100, 32'h0, 32'hFFFFBEEF, 0, 1);
    req(0, "r_hu", 1, 0, 4'b0001, 32'h102, 32'h0, 32'h0000DEAD, 0, 1);
    req(0, "r_prio_b", 1, 0, 4'b1111, 32'h103, 32'h0, 32'hFFFFFFDE, 0, 1);
    req(0, "r_prio_h", 1, 0, 4'b0011, 32'h102, 32'h0, 32'hFFFFDEAD, 0, 1);
    req(0, "r_h_odd", 1, 0, 4'b0001, 32'h103, 32'h0, 32'h0000DEAD, 0, 1);
    req(0, "r_w_unal", 1, 1, 4'b0000, 32'h102, 32'h0, 32'hDEADBEEF, 0, 1);

    // Lane-masked byte store
    req(0, "w_byte", 0, 1, 4'b0100, 32'h101, 32'h12345678, 32'h0, 0, 1);
    req(0, "r_after_b", 1, 0, 4'b0000, 32'h100, 32'h0, 32'hDEAD78EF, 0, 1);

    // Range boundary
    req(0, "w_zero", 0, 1, 4'b0000, 32'h0, 32'h11223344, 32'h0, 0, 1);
    req(0, "w_last", 0, 1, 4'b0000, 32'hFFC, 32'hCAFEF00D, 32'h0, 0, 1);
    req(0, "r_last", 1, 0, 4'b0000, 32'hFFC, 32'h0, 32'hCAFEF00D, 0, 1);
    req(0, "r_oor", 1, 0, 4'b0000, 32'h1000, 32'h0, 32'h0, 1, 1);
    req(0, "w_oor", 0, 1, 4'b0000, 32'h1000, 32'hA5A5A5A5, 32'h0, 1, 1);
    req(0, "r_zero", 1, 0, 4'b0000, 32'h0, 32'h0, 32'h11223344, 0, 1);
    req(0, "r_100", 1, 0, 4'b0000, 32'h100, 32'h0, 32'hDEAD78EF, 0, 1);

    // Strobe without a qualifier is ignored
    @(negedge clk);
    ar[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("noqual_dr", {31'b0, dr[0]}, 32'h0);
    end
    ar[0] = 1'b0;

    // Strobe held after the response: single pulse, then a fresh request
    req(0, "hold", 1, 0, 4'b0000, 32'h100, 32'h0, 32'hDEAD78EF, 0, 5);
    req(0, "after_hold", 1, 0, 4'b0000, 32'hFFC, 32'h0, 32'hCAFEF00D, 0, 1);

    // Abort in WAIT on the three-wait-state instance
    req(1, "w3_init", 0, 1, 4'b0000, 32'h300, 32'h55AA55AA, 32'h0, 0, 1);
    @(negedge clk);
    addr = 32'h300; bus = 32'hFFFFFFFF; mem_write = 1'b1; mem_size = '0; ar[1] = 1'b1;
    @(negedge clk);
    ar[1] = 1'b0; mem_write = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_dr", {31'b0, dr[1]}, 32'h0);
    end
    req(1, "abort_rd", 1, 0, 4'b0000, 32'h300, 32'h0, 32'h55AA55AA, 0, 1);

    // Reset during WAIT cancels the write
    @(negedge clk);
    addr = 32'h300; bus = 32'h0BADF00D; mem_write = 1'b1; mem_size = '0; ar[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("rwait_dr", {31'b0, dr[1]}, 32'h0);
    #1 reset = 1'b0;
    #1;
    check("rwait_dr_rst", {31'b0, dr[1]}, 32'h0);
    check("rwait_oe_rst", {31'b0, oe[1]}, 32'h0);
    check("rwait_out_rst", out1, 32'h0);
    @(negedge clk);
    ar[1] = 1'b0; mem_write = 1'b0; reset = 1'b1;
    req(1, "rwait_rd", 1, 0, 4'b0000, 32'h300, 32'h0, 32'h55AA55AA, 0, 1);

    // Reset during RESP clears the driven outputs without waiting for a clock
    @(negedge clk);
    addr = 32'h100; mem_read = 1'b1; mem_size = '0; ar[0] = 1'b1;
    sb0.push_back('{"rresp", 32'hDEAD78EF, 1'b0, 1'b1});
    repeat (2) @(negedge clk);
    check("rresp_dr_before", {31'b0, dr[0]}, 32'h1);
    #1 reset = 1'b0;
    #1;
    check("rresp_dr_rst", {31'b0, dr[0]}, 32'h0);
    check("rresp_oe_rst", {31'b0, oe[0]}, 32'h0);
    check("rresp_out_rst", out0, 32'h0);
    @(negedge clk);
    ar[0] = 1'b0; mem_read = 1'b0; reset = 1'b1;
    req(0, "rresp_rd", 1, 0, 4'b0000, 32'h100, 32'h0, 32'hDEAD78EF, 0, 1);

    // Random sub-word traffic against a small reference model
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      req(0, "rnd_init", 0, 1, 4'b0000, 32'h200 + 32'(4 * i), d, 32'h0, 0, 1);
      model[i] = d;
    end
    for (int i = 0; i < 16; i++) begin
      a  = 32'h200 + 32'($urandom_range(0, 15));
      sz = szs[$urandom_range(0, 4)];
      rd = 1'($urandom_range(0, 1));
      d  = $urandom;
      if (rd) begin
        req(0, "rnd_rd", 1, 0, sz, a, 32'h0, m_read(a, sz), 0, 1);
      end else begin
        req(0, "rnd_wr", 0, 1, sz, a, d, 32'h0, 0, 1);
        m_write(a, sz, d);
      end
    end
    for (int i = 0; i < 4; i++)
      req(0, "rnd_final", 1, 0, 4'b0000, 32'h200 + 32'(4 * i), 32'h0, model[i], 0, 1);

    repeat (3) @(negedge clk);
    check("sb0_empty", 32'(sb0.size()), 32'h0);
    check("sb1_empty", 32'(sb1.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing array.
REQ-002 Parameter WAIT_STATES, default 1, extra cycles between request acceptance and response, range 0..15.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 addr  input  32  byte address of the access.
REQ-006 bus  input  32  store data, valid with the request.
REQ-007 mem_read  input  1  read request qualifier.
REQ-008 mem_write  input  1  write request qualifier.
REQ-009 mem_size  input  4  {byte signed, byte unsigned, half signed, half unsigned}; 4'b0000 = word.
REQ-010 mem_addr_ready  input  1  initiator strobe: address, size and data valid.
REQ-011 mem_data_ready  output  1  one-cycle response pulse: access complete.
REQ-012 mem_bus_out  output  32  read data, extended to 32 bits.
REQ-013 mem_bus_oe  output  1  high while mem_bus_out drives the shared bus.
REQ-014 mem_err  output  1  out-of-range flag, valid with mem_data_ready.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT, RESP and HOLD.
REQ-016 In IDLE, mem_addr_ready & (mem_read | mem_write) SHALL latch addr, mem_size, bus and the op; mem_read wins if both qualifiers are high.
REQ-017 On acceptance, the wait counter SHALL load WAIT_STATES; the next state is WAIT, or RESP when WAIT_STATES = 0.
REQ-018 In WAIT, the counter SHALL decrement each cycle; at 0 the next state is RESP.
REQ-019 Latency: a request sampled at posedge N SHALL produce mem_data_ready high during cycle N+WAIT_STATES+1, for exactly one cycle.
REQ-020 A write SHALL update the array on the edge entering RESP, touching only the selected byte lanes.
REQ-021 Byte accesses SHALL use lane addr[1:0]; half accesses SHALL use lanes {addr[1],1},{addr[1],0}, ignoring addr[0]; word accesses SHALL use all lanes, ignoring addr[1:0].
REQ-022 Store data SHALL come from the latched bus: bus[7:0] for bytes, bus[15:0] for halves, bus[31:0] for words.
REQ-023 mem_size priority SHALL be bit3 > bit2 > bit1 > bit0 when more than one bit is set.
REQ-024 Read data SHALL be right-justified; signed sizes sign-extend and unsigned sizes zero-extend.
REQ-025 mem_bus_out and mem_bus_oe SHALL be registered and valid only in RESP for reads; otherwise mem_bus_oe = 0 and mem_bus_out = 0.
REQ-026 A word index >= DEPTH_WORDS SHALL assert mem_err with mem_data_ready; such writes are dropped and such reads return 0.
REQ-027 After RESP the FSM SHALL enter HOLD and return to IDLE only once mem_addr_ready is sampled low; a request is never accepted from HOLD.
REQ-028 If mem_addr_ready falls during WAIT (abort), the FSM SHALL return to IDLE next cycle, with no array write and no mem_data_ready pulse.
REQ-029 mem_addr_ready high with neither qualifier high SHALL be ignored.

Reset
REQ-030 On reset low, the FSM SHALL go to IDLE immediately, and the counter, mem_data_ready, mem_bus_oe, mem_err and mem_bus_out SHALL go to 0.
REQ-031 Reset mid-access SHALL cancel the access with no array write; array contents are not cleared by reset.

Structure
REQ-032 The FSM state enum and the mem_size bit positions SHALL live in a shared package also used by the control unit.
REQ-033 The backing storage SHALL be a sub-module mem_array: one synchronous read/write port, per-byte write enables, no reset.

Verification
REQ-034 Word write/read, WAIT_STATES=1: write 0xDEADBEEF to 0x100, then read 0x100 word -> mem_data_ready exactly 2 cycles after each strobe; read returns 0xDEADBEEF with mem_bus_oe high for one cycle.
REQ-035 Byte/half extension: after REQ-034, byte-signed read at 0x103 -> 0xFFFFFFDE; byte-unsigned at 0x103 -> 0x000000DE; half-signed at 0x100 -> 0xFFFFBEEF; half-unsigned at 0x102 -> 0x0000DEAD.
REQ-036 Lane-masked store: byte write of bus=0x12345678 to 0x101 over 0xDEADBEEF -> word read of 0x100 returns 0xDEAD78EF.
REQ-037 Out of range, DEPTH_WORDS=1024: read 0x1000 -> mem_err=1 with mem_data_ready, data 0; write 0x1000 -> no change to any in-range word.
REQ-038 Abort/reset: WAIT_STATES=3, drop mem_addr_ready after 1 cycle of a write -> no pulse, target unchanged; repeat, asserting reset in WAIT -> outputs 0 asynchronously, no write.
REQ-039 Hold: keep mem_addr_ready high for 5 cycles after the response -> only one mem_data_ready pulse, and the next request is accepted only after mem_addr_ready goes low.
